// File: rtl/ledarray_if.sv
// ledarray_if: control, frame-store write and display signals of the LED sequencer
interface ledarray_if #(parameter int FW = 2);
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [FW-1:0] nframes_m1;
  logic [7:0]    repeat_m1;
  logic          wr_en;
  logic [FW-1:0] wr_frame;
  logic [4:0]    wr_row;
  logic [4:0]    wr_data;
  logic [4:0]    dot;
  logic [4:0]    row;
  logic [FW-1:0] frame;
  logic          busy;
  logic          done;
  modport master (
    output start, stop, loop_en, nframes_m1, repeat_m1, wr_en, wr_frame, wr_row, wr_data,
    input  dot, row, frame, busy, done
  );
  modport slave (
    input  start, stop, loop_en, nframes_m1, repeat_m1, wr_en, wr_frame, wr_row, wr_data,
    output dot, row, frame, busy, done
  );
endinterface

// File: rtl/ledarray_sequencer.sv
// ledarray_sequencer: plays stored 32x5 frames onto the LED dot array with repeats, gaps and looping
module ledarray_sequencer #(
  parameter int NFRAMES    = 4,
  parameter int FW         = 2,
  parameter int GAP_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  ledarray_if.slave bus
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SCAN, GAP, DONE} state_t;
  state_t        r_state;
  logic [4:0]    r_mem [NFRAMES][32];
  logic [4:0]    r_row;
  logic [FW-1:0] r_frame;
  logic [FW-1:0] r_last;
  logic [7:0]    r_rep;
  logic [7:0]    r_rep_m1;
  logic          r_loop;
  logic [GW-1:0] r_gap;
  logic          r_busy;
  logic          r_done;
  logic          w_row_end;
  logic          w_frame_end;
  logic          w_last;
  logic [FW-1:0] w_next_frame;
  assign w_row_end    = r_row == 5'd31;
  assign w_frame_end  = w_row_end && r_rep == r_rep_m1;
  assign w_last       = r_frame == r_last;
  assign w_next_frame = w_last ? '0 : r_frame + 1'b1;
  assign bus.dot   = r_state == SCAN ? r_mem[r_frame][r_row] : '0;
  assign bus.row   = r_row;
  assign bus.frame = r_frame;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  // Frame store: written in any state; the display read sees the old word until the edge
  always_ff @(posedge clk)
    if (bus.wr_en) r_mem[bus.wr_frame][bus.wr_row] <= bus.wr_data;
  // Playback FSM; the nframes_m1 field is FW bits wide, so the latched last frame never exceeds NFRAMES-1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_row    <= '0;
      r_frame  <= '0;
      r_last   <= '0;
      r_rep    <= '0;
      r_rep_m1 <= '0;
      r_loop   <= 1'b0;
      r_gap    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.stop) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_frame <= '0;
      r_rep   <= '0;
      r_gap   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else
      case (r_state)
        IDLE:
          if (bus.start) begin
            r_state  <= SCAN;
            r_row    <= '0;
            r_frame  <= '0;
            r_rep    <= '0;
            r_last   <= bus.nframes_m1;
            r_rep_m1 <= bus.repeat_m1;
            r_loop   <= bus.loop_en;
            r_busy   <= 1'b1;
          end
        SCAN: begin
          r_row <= r_row + 1'b1;
          if (w_row_end) begin
            if (!w_frame_end) r_rep <= r_rep + 1'b1;
            else if (w_last && !r_loop) begin
              r_state <= DONE;
              r_frame <= '0;
              r_rep   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (GAP_CYCLES > 0) begin
              r_state <= GAP;
              r_gap   <= '0;
              r_rep   <= '0;
            end else begin
              r_frame <= w_next_frame;
              r_rep   <= '0;
            end
          end
        end
        GAP:
          if (r_gap == GAP_LAST) begin
            r_state <= SCAN;
            r_frame <= w_next_frame;
            r_gap   <= '0;
          end else r_gap <= r_gap + 1'b1;
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
endmodule
